fft_stage_scheduler: RTL and testbench
======================================

// Module: fft_stage_scheduler
// PURPOSE
//  Sequences a radix-2 in-place DIT FFT over the butterfly datapath: walks stages and butterflies and issues
//  operand/twiddle addresses with a valid/ready handshake. Tracks in-flight butterflies and drains each stage
//  before starting the next. Applies block-floating-point rescaling from butterfly overflow flags and accumulates
//  the scale factor that the register block reports. Sits between the FFT control registers and the butterfly/memory pipeline.
// PARAMETERS
//  FFT_MAX_LENGTH_LOG2  12  max transform log2; sets address widths (ADDR_W = FFT_MAX_LENGTH_LOG2)
//  MAX_OUTSTANDING      8   max butterflies issued but not yet retired (pipeline depth), power of 2 not required
// PORTS
//  clk_i             in   1       system clock
//  reset_i           in   1       asynchronous reset, active-high
//  start_i           in   1       start pulse; ignored unless IDLE
//  abort_i           in   1       abandon transform, return to IDLE
//  length_log2_i     in   4       log2 N, valid range 1..FFT_MAX_LENGTH_LOG2, sampled on accepted start
//  rescale_en_i      in   1       enable auto-rescale, sampled on accepted start
//  bf_valid_o        out  1       butterfly command valid
//  bf_ready_i        in   1       datapath accepts command
//  addr_a_o          out  ADDR_W  top operand address
//  addr_b_o          out  ADDR_W  bottom operand address
//  twiddle_addr_o    out  ADDR_W-1 twiddle ROM index (table sized for max length)
//  stage_o           out  4       current stage index
//  scale_shift_o     out  1       datapath shifts results right by 1 this stage
//  bf_done_i         in   1       one butterfly retired
//  overflow_i        in   1       retired butterfly exceeded half-range; qualified by bf_done_i
//  busy_o            out  1       transform in progress
//  done_o            out  1       one-cycle completion pulse
//  error_o           out  1       one-cycle pulse: bad length or spurious retire
//  scale_factor_o    out  8       total right-shifts applied in last/current transform
// BEHAVIOUR
//  Reset: state IDLE; every output 0; counters and scale_factor_o cleared.
//  FSM: IDLE -start,valid length-> ISSUE; ISSUE -last bf of stage accepted-> DRAIN; DRAIN -outstanding==0->
//   last stage ? DONE : NEXT; NEXT (1 cycle: stage++, k=0, rescale decision) -> ISSUE; DONE (done_o=1) -> IDLE.
//  start_i with length_log2_i==0 or >FFT_MAX_LENGTH_LOG2: error_o pulse, stay IDLE, scale_factor_o unchanged.
//  Accepted start clears scale_factor_o, stage=0, k=0, scale_shift_o=0; bf_valid_o first high next cycle.
//  Issue: bf_valid_o = (state==ISSUE) && outstanding<MAX_OUTSTANDING; transfer on valid&&ready; k++ per transfer.
//   Outputs hold stable while valid&&!ready.
//  Addressing, stage s, butterfly k in 0..N/2-1: half=1<<s; pos=k&(half-1); grp=k>>s;
//   addr_a=(grp<<(s+1))|pos; addr_b=addr_a+half; twiddle=pos<<(FFT_MAX_LENGTH_LOG2-1-s).
//  Outstanding counter: +1 on transfer, -1 on bf_done_i, unchanged when both same cycle.
//   bf_done_i with outstanding==0 and no same-cycle transfer: error_o pulse, counter stays 0, retire ignored.
//  Overflow: sticky flag set by bf_done_i&&overflow_i during ISSUE/DRAIN; cleared in NEXT.
//   In NEXT: scale_shift_o = rescale_en && sticky; if set, scale_factor_o++ saturating at 255.
//   Overflow in the last stage only sets nothing further (no following stage); not counted.
//  done_o one cycle after DRAIN sees outstanding==0 in last stage; busy_o high from accepted start through DONE cycle.
//  abort_i (any state but IDLE): next cycle IDLE, bf_valid_o=0, busy_o=0, no done_o, counters cleared;
//   scale_factor_o retains value. abort_i wins over start_i in same cycle. Async reset mid-op = reset values.
// CONFIGURATION
//  FFT_SCHED_PERF_EN defined: adds port perf_cycles_o out 32 = clk cycles from accepted start to done_o
//   inclusive, cleared on start, saturating at 2^32-1, held after done; plus stall_cycles_o out 32 counting
//   cycles with bf_valid_o&&!bf_ready_i. Not defined: ports absent, no counters synthesized.
// TESTING
//  N=8, ready=1, bf_done_i 2 cycles after each transfer: 12 transfers; s0 k=1 -> a=2,b=3,tw=0; s1 k=1 -> a=1,b=3,tw=1024;
//   s2 k=3 -> a=3,b=7,tw=1536; stage_o 0,1,2; single done_o pulse, scale_factor_o=0.
//  N=16, rescale_en=1, overflow_i on one retire in stages 0 and 1 -> scale_shift_o=1 in stages 1,2; scale_factor_o=2.
//  Same with rescale_en=0 -> scale_shift_o never 1, scale_factor_o=0.
//  Hold bf_done_i low, ready=1 -> exactly MAX_OUTSTANDING(8) transfers then bf_valid_o low; one retire -> one more issue.
//  length_log2_i=0 and 13 with start -> error_o pulse, busy_o stays 0; retire while idle -> error_o pulse.
//  abort_i mid stage 1 of N=1024 -> IDLE next cycle, no done_o; new start N=4 completes 4 transfers normally.

Source files
------------

// File: rtl/fft_stage_scheduler.sv
// Radix-2 in-place DIT FFT stage/butterfly sequencer with block-floating-point
// rescale tracking and an in-flight limit toward the butterfly pipeline.
//
// Ports:
//   clk_i, reset_i (async, active-high)
//   start_i, abort_i, length_log2_i, rescale_en_i : control inputs
//   bf_valid_o/bf_ready_i, addr_a_o, addr_b_o, twiddle_addr_o,
//   stage_o, scale_shift_o : butterfly command channel
//   bf_done_i, overflow_i : retire feedback
//   busy_o, done_o, error_o, scale_factor_o : status
//
// Optional macro FFT_SCHED_PERF_EN adds perf_cycles_o and stall_cycles_o.
module fft_stage_scheduler #(
   parameter int FFT_MAX_LENGTH_LOG2 = 12,
   parameter int MAX_OUTSTANDING     = 8
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic                           start_i,
   input  logic                           abort_i,
   input  logic [3:0]                     length_log2_i,
   input  logic                           rescale_en_i,
   output logic                           bf_valid_o,
   input  logic                           bf_ready_i,
   output logic [FFT_MAX_LENGTH_LOG2-1:0] addr_a_o,
   output logic [FFT_MAX_LENGTH_LOG2-1:0] addr_b_o,
   output logic [FFT_MAX_LENGTH_LOG2-2:0] twiddle_addr_o,
   output logic [3:0]                     stage_o,
   output logic                           scale_shift_o,
   input  logic                           bf_done_i,
   input  logic                           overflow_i,
   output logic                           busy_o,
   output logic                           done_o,
   output logic                           error_o,
   output logic [7:0]                     scale_factor_o
`ifdef FFT_SCHED_PERF_EN
   ,
   output logic [31:0]                    perf_cycles_o,
   output logic [31:0]                    stall_cycles_o
`endif
);

   localparam int AW = FFT_MAX_LENGTH_LOG2;
   localparam int KW = AW - 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [3:0]    SMAX = 4'(AW - 1);
   localparam logic [3:0]    LMAX = 4'(AW);
   localparam logic [OW-1:0] OMAX = OW'(MAX_OUTSTANDING);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_DRAIN, S_NEXT, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    stage_q, stage_d;
   logic [3:0]    len_q, len_d;
   logic [KW-1:0] k_q, k_d;
   logic [OW-1:0] outst_q, outst_d;
   logic          rescale_q, rescale_d;
   logic          sticky_q, sticky_d;
   logic          shift_q, shift_d;
   logic          error_q, error_d;
   logic [7:0]    scale_q, scale_d;

   logic          xfer, spurious, retire;
   logic          len_ok, start_ok, last_k, last_stage, do_shift;
   logic [KW-1:0] kmask, pos, k_last;
   logic [AW-1:0] grp, half, addr_a;

   assign len_ok   = (length_log2_i != 4'd0) && (length_log2_i <= LMAX);
   assign start_ok = (state_q == S_IDLE) && start_i && !abort_i && len_ok;

   assign bf_valid_o = (state_q == S_ISSUE) && (outst_q < OMAX);
   assign xfer       = bf_valid_o && bf_ready_i;
   // A retire with nothing in flight is only legal if it pairs with a
   // same-cycle issue; otherwise it is dropped and flagged.
   assign spurious   = bf_done_i && (outst_q == '0) && !xfer;
   assign retire     = bf_done_i && !spurious;

   // k splits into group (high bits) and position (low s bits).
   assign k_last = ~({KW{1'b1}} << (len_q - 4'd1));
   assign kmask  = ~({KW{1'b1}} << stage_q);
   assign pos    = k_q & kmask;
   assign grp    = {1'b0, k_q} >> stage_q;
   assign half   = {{KW{1'b0}}, 1'b1} << stage_q;
   assign addr_a = (grp << (stage_q + 4'd1)) | {1'b0, pos};

   assign last_k     = (k_q == k_last);
   assign last_stage = (stage_q == (len_q - 4'd1));
   assign do_shift   = rescale_q && sticky_q;

   always_comb begin
      state_d   = state_q;
      stage_d   = stage_q;
      len_d     = len_q;
      k_d       = k_q;
      outst_d   = outst_q;
      rescale_d = rescale_q;
      sticky_d  = sticky_q;
      shift_d   = shift_q;
      scale_d   = scale_q;
      error_d   = spurious;

      if (xfer && !retire) begin
         outst_d = outst_q + 1'b1;
      end else if (retire && !xfer) begin
         outst_d = outst_q - 1'b1;
      end

      if ((state_q == S_ISSUE || state_q == S_DRAIN) &&
          bf_done_i && overflow_i) begin
         sticky_d = 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (start_i && !abort_i) begin
               if (len_ok) begin
                  state_d   = S_ISSUE;
                  len_d     = length_log2_i;
                  rescale_d = rescale_en_i;
                  stage_d   = '0;
                  k_d       = '0;
                  sticky_d  = 1'b0;
                  shift_d   = 1'b0;
                  scale_d   = '0;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            if (xfer) begin
               k_d = k_q + 1'b1;
               if (last_k) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (outst_q == '0) begin
               state_d = last_stage ? S_DONE : S_NEXT;
            end
         end
         S_NEXT: begin
            stage_d  = stage_q + 4'd1;
            k_d      = '0;
            sticky_d = 1'b0;
            shift_d  = do_shift;
            if (do_shift && scale_q != 8'hFF) begin
               scale_d = scale_q + 8'd1;
            end
            state_d  = S_ISSUE;
         end
         S_DONE: begin
            state_d = S_IDLE;
            stage_d = '0;
            k_d     = '0;
            shift_d = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort_i && state_q != S_IDLE) begin
         state_d  = S_IDLE;
         stage_d  = '0;
         k_d      = '0;
         outst_d  = '0;
         sticky_d = 1'b0;
         shift_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         stage_q   <= '0;
         len_q     <= '0;
         k_q       <= '0;
         outst_q   <= '0;
         rescale_q <= 1'b0;
         sticky_q  <= 1'b0;
         shift_q   <= 1'b0;
         scale_q   <= '0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         stage_q   <= stage_d;
         len_q     <= len_d;
         k_q       <= k_d;
         outst_q   <= outst_d;
         rescale_q <= rescale_d;
         sticky_q  <= sticky_d;
         shift_q   <= shift_d;
         scale_q   <= scale_d;
         error_q   <= error_d;
      end
   end

   // Command fields are forced to zero whenever no command is offered.
   assign addr_a_o       = bf_valid_o ? addr_a : '0;
   assign addr_b_o       = bf_valid_o ? (addr_a + half) : '0;
   assign twiddle_addr_o = bf_valid_o ? (pos << (SMAX - stage_q)) : '0;
   assign stage_o        = stage_q;
   assign scale_shift_o  = shift_q;
   assign busy_o         = (state_q != S_IDLE);
   assign done_o         = (state_q == S_DONE);
   assign error_o        = error_q;
   assign scale_factor_o = scale_q;

`ifdef FFT_SCHED_PERF_EN
   logic [31:0] perf_q, stall_q;

   // The start cycle counts as 1; every busy cycle through DONE adds one.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         perf_q  <= '0;
         stall_q <= '0;
      end else if (start_ok) begin
         perf_q  <= 32'd1;
         stall_q <= '0;
      end else begin
         if (busy_o && !abort_i && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
         end
         if (bf_valid_o && !bf_ready_i && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
         end
      end
   end

   assign perf_cycles_o  = perf_q;
   assign stall_cycles_o = stall_q;
`else
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Scoreboard bench for fft_stage_scheduler: stimulus pushes expected
// butterfly commands, a negedge monitor pops and compares on each transfer.
module tb_fft_stage_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic        abort_i = 1'b0;
   logic [3:0]  length_log2_i = '0;
   logic        rescale_en_i = 1'b0;
   logic        bf_valid_o;
   logic        bf_ready_i = 1'b1;
   logic [11:0] addr_a_o, addr_b_o;
   logic [10:0] twiddle_addr_o;
   logic [3:0]  stage_o;
   logic        scale_shift_o;
   logic        bf_done_i = 1'b0;
   logic        overflow_i = 1'b0;
   logic        busy_o, done_o, error_o;
   logic [7:0]  scale_factor_o;

   fft_stage_scheduler dut (
      .clk_i(clk), .reset_i(rst), .start_i(start_i), .abort_i(abort_i),
      .length_log2_i(length_log2_i), .rescale_en_i(rescale_en_i),
      .bf_valid_o(bf_valid_o), .bf_ready_i(bf_ready_i),
      .addr_a_o(addr_a_o), .addr_b_o(addr_b_o),
      .twiddle_addr_o(twiddle_addr_o), .stage_o(stage_o),
      .scale_shift_o(scale_shift_o), .bf_done_i(bf_done_i),
      .overflow_i(overflow_i), .busy_o(busy_o), .done_o(done_o),
      .error_o(error_o), .scale_factor_o(scale_factor_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [11:0] a;
      logic [11:0] b;
      logic [10:0] tw;
      logic [3:0]  st;
      logic        sh;
   } cmd_t;

   cmd_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   xfer_cnt = 0;
   int   done_cnt = 0;
   int   err_cnt = 0;
   bit   sb_en = 1'b1;
   bit   auto_ret = 1'b1;
   bit   ov_mode = 1'b0;
   bit   xfer_neg = 1'b0;
   bit   ov_neg = 1'b0;
   bit   p0 = 1'b0, p1 = 1'b0, po0 = 1'b0, po1 = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor / scoreboard.
   always @(negedge clk) begin
      cmd_t e;
      xfer_neg = 1'b0;
      ov_neg   = 1'b0;
      if (bf_valid_o && bf_ready_i) begin
         xfer_cnt++;
         xfer_neg = 1'b1;
         ov_neg   = ov_mode && (stage_o < 4'd2) && (addr_a_o == 12'd0);
         if (sb_en) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL sb_unexpected: a=%0d b=%0d with empty queue",
                        addr_a_o, addr_b_o);
            end else begin
               e = exp_q.pop_front();
               chk("cmd_a", int'(addr_a_o), int'(e.a));
               chk("cmd_b", int'(addr_b_o), int'(e.b));
               chk("cmd_tw", int'(twiddle_addr_o), int'(e.tw));
               chk("cmd_stage", int'(stage_o), int'(e.st));
               chk("cmd_shift", int'(scale_shift_o), int'(e.sh));
            end
         end
      end
      if (done_o)  done_cnt++;
      if (error_o) err_cnt++;
   end

   // Datapath model: retire each transfer two cycles later.
   always @(posedge clk) begin
      #1;
      if (auto_ret) begin
         bf_done_i  = p1;
         overflow_i = p1 && po1;
      end
      p1  = p0;
      po1 = po0;
      p0  = xfer_neg;
      po0 = ov_neg;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int len, input bit ren);
      @(posedge clk);
      #1;
      start_i       = 1'b1;
      length_log2_i = 4'(len);
      rescale_en_i  = ren;
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   task automatic push(input int a, input int b, input int tw,
                       input int st, input bit sh);
      cmd_t c;
      c.a  = 12'(a);
      c.b  = 12'(b);
      c.tw = 11'(tw);
      c.st = 4'(st);
      c.sh = sh;
      exp_q.push_back(c);
   endtask

   // Group/position walk; shmask marks stages expected to shift.
   task automatic push_fft(input int len, input int shmask);
      int n = 1 << len;
      for (int s = 0; s < len; s++) begin
         int h = 1 << s;
         for (int g = 0; g < n; g += 2 * h) begin
            for (int p = 0; p < h; p++) begin
               push(g + p, g + p + h, p * (2048 / h), s, shmask[s]);
            end
         end
      end
   endtask

   task automatic wait_done(input int base, input int lim, input string nm);
      int n = 0;
      while (done_cnt == base && n < lim) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt == base) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: no done_o within %0d cycles", nm, lim);
      end
   endtask

   initial begin
      int d0, x0, e0, n;
      int a8[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
      int b8[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
      int t8[12]  = '{0, 0, 0, 0, 0, 1024, 0, 1024, 0, 512, 1024, 1536};
      int a4[4]   = '{0, 2, 0, 1};
      int b4[4]   = '{1, 3, 2, 3};
      int t4[4]   = '{0, 0, 0, 1024};

      // Reset state.
      @(negedge clk);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_valid", int'(bf_valid_o), 0);
      chk("rst_done", int'(done_o), 0);
      chk("rst_error", int'(error_o), 0);
      chk("rst_scale", int'(scale_factor_o), 0);
      chk("rst_addr_b", int'(addr_b_o), 0);
      chk("rst_stage", int'(stage_o), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      cyc(2);

      // N=8, hand table.
      for (int i = 0; i < 12; i++) push(a8[i], b8[i], t8[i], i / 4, 1'b0);
      d0 = done_cnt;
      x0 = xfer_cnt;
      do_start(3, 1'b0);
      @(negedge clk);
      chk("n8_busy", int'(busy_o), 1);
      wait_done(d0, 200, "n8");
      cyc(4);
      chk("n8_xfers", xfer_cnt - x0, 12);
      chk("n8_done_pulses", done_cnt - d0, 1);
      chk("n8_scale", int'(scale_factor_o), 0);
      chk("n8_queue_left", exp_q.size(), 0);
      chk("n8_busy_after", int'(busy_o), 0);

      // N=16 with rescale: overflow in stages 0 and 1.
      ov_mode = 1'b1;
      push_fft(4, 'b0110);
      d0 = done_cnt;
      do_start(4, 1'b1);
      wait_done(d0, 400, "n16r");
      cyc(3);
      chk("n16r_scale", int'(scale_factor_o), 2);
      chk("n16r_queue_left", exp_q.size(), 0);
      ov_mode = 1'b0;

      // Bad lengths and spurious retire.
      e0 = err_cnt;
      do_start(0, 1'b0);
      @(negedge clk);
      chk("len0_busy", int'(busy_o), 0);
      cyc(2);
      chk("len0_err", err_cnt - e0, 1);
      chk("len0_scale_kept", int'(scale_factor_o), 2);
      e0 = err_cnt;
      do_start(13, 1'b0);
      @(negedge clk);
      chk("len13_busy", int'(busy_o), 0);
      cyc(2);
      chk("len13_err", err_cnt - e0, 1);
      auto_ret = 1'b0;
      e0 = err_cnt;
      bf_done_i = 1'b1;
      cyc(1);
      bf_done_i = 1'b0;
      cyc(2);
      chk("idle_retire_err", err_cnt - e0, 1);
      chk("idle_retire_busy", int'(busy_o), 0);
      auto_ret = 1'b1;

      // N=16, overflow present but rescale disabled.
      ov_mode = 1'b1;
      push_fft(4, 0);
      d0 = done_cnt;
      do_start(4, 1'b0);
      wait_done(d0, 400, "n16n");
      cyc(3);
      chk("n16n_scale", int'(scale_factor_o), 0);
      chk("n16n_queue_left", exp_q.size(), 0);
      ov_mode = 1'b0;

      // Outstanding limit with retires held off.
      auto_ret = 1'b0;
      for (int k = 0; k < 9; k++) push(2 * k, 2 * k + 1, 0, 0, 1'b0);
      x0 = xfer_cnt;
      e0 = err_cnt;
      do_start(10, 1'b0);
      cyc(20);
      @(negedge clk);
      chk("lim_xfers", xfer_cnt - x0, 8);
      chk("lim_valid_low", int'(bf_valid_o), 0);
      cyc(1);
      bf_done_i = 1'b1;
      cyc(1);
      bf_done_i = 1'b0;
      cyc(5);
      @(negedge clk);
      chk("lim_xfers_after_retire", xfer_cnt - x0, 9);
      chk("lim_valid_low2", int'(bf_valid_o), 0);
      chk("lim_no_err", err_cnt - e0, 0);
      chk("lim_queue_left", exp_q.size(), 0);
      cyc(1);
      abort_i = 1'b1;
      cyc(1);
      abort_i = 1'b0;
      @(negedge clk);
      chk("lim_abort_busy", int'(busy_o), 0);
      cyc(2);
      auto_ret = 1'b1;

      // Abort in stage 1 of N=1024.
      sb_en = 1'b0;
      d0 = done_cnt;
      do_start(10, 1'b0);
      n = 0;
      while (stage_o != 4'd1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reached_s1", int'(stage_o), 1);
      cyc(10);
      abort_i = 1'b1;
      start_i = 1'b1;
      length_log2_i = 4'd2;
      cyc(1);
      abort_i = 1'b0;
      start_i = 1'b0;
      @(negedge clk);
      chk("abort_busy", int'(busy_o), 0);
      chk("abort_valid", int'(bf_valid_o), 0);
      cyc(10);
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_still_idle", int'(busy_o), 0);
      sb_en = 1'b1;

      // N=4 after abort.
      for (int i = 0; i < 4; i++) push(a4[i], b4[i], t4[i], i / 2, 1'b0);
      d0 = done_cnt;
      x0 = xfer_cnt;
      do_start(2, 1'b0);
      wait_done(d0, 100, "n4");
      cyc(3);
      chk("n4_xfers", xfer_cnt - x0, 4);
      chk("n4_done_pulses", done_cnt - d0, 1);
      chk("n4_queue_left", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
